// File: rtl/pattern_det_pkg.sv
// Shared constants and elaboration-time helpers for the serial pattern detector:
// default pattern, state width and the KMP next-state table builder.
package pattern_det_pkg;

    localparam int MAX_LEN = 64;
    localparam int IDX_W   = $clog2(MAX_LEN);
    localparam int ENTRY_W = 8;
    localparam int TBL_W   = 2 * MAX_LEN * ENTRY_W;

    // Symbols B,C,C,B,C with B=0, C=1, first symbol in the MSB
    localparam int         DEFAULT_LEN     = 5;
    localparam logic [4:0] DEFAULT_PATTERN = 5'b01101;

    function automatic int state_width(input int len);
        return $clog2(len + 1);
    endfunction

    // Symbol i of the pattern in arrival order
    function automatic logic sym_at(input logic [MAX_LEN-1:0] pat, input int len, input int i);
        return pat[IDX_W'(len - 1 - i)];
    endfunction

    // Longest prefix that is a suffix of (first k pattern symbols, b)
    function automatic int next_prefix(input logic [MAX_LEN-1:0] pat, input int len,
                                       input int k, input logic b);
        int   res;
        logic ok;
        res = 0;
        if (sym_at(pat, len, k) == b) begin
            res = k + 1;
        end else begin
            for (int j = 1; j <= k; j++) begin
                ok = (sym_at(pat, len, j - 1) == b);
                for (int i = 0; i < j - 1; i++) begin
                    if (sym_at(pat, len, i) != sym_at(pat, len, k - j + 1 + i)) begin
                        ok = 1'b0;
                    end else begin
                        ok = ok;
                    end
                end
                if (ok) begin
                    res = j;
                end else begin
                    res = res;
                end
            end
        end
        return res;
    endfunction

    // Longest proper border of the whole pattern (restart point in overlap mode)
    function automatic int border_len(input logic [MAX_LEN-1:0] pat, input int len);
        int   res;
        logic ok;
        res = 0;
        for (int j = 1; j < len; j++) begin
            ok = 1'b1;
            for (int i = 0; i < j; i++) begin
                if (sym_at(pat, len, i) != sym_at(pat, len, len - j + i)) begin
                    ok = 1'b0;
                end else begin
                    ok = ok;
                end
            end
            if (ok) begin
                res = j;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Entry (2*k + b) holds the next prefix length from state k on symbol b
    function automatic logic [TBL_W-1:0] build_next_table(input logic [MAX_LEN-1:0] pat,
                                                          input int len);
        logic [TBL_W-1:0] tbl;
        tbl = {TBL_W{1'b0}};
        for (int k = 0; k < len; k++) begin
            for (int b = 0; b < 2; b++) begin
                tbl[(2 * k + b) * ENTRY_W +: ENTRY_W] = ENTRY_W'(next_prefix(pat, len, k, 1'(b)));
            end
        end
        return tbl;
    endfunction

endpackage

// File: rtl/pattern_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter
#(
    parameter int W = 16
)
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o
);

    localparam logic [W-1:0] MAX_VAL = {W{1'b1}};

    logic [W-1:0] count_r;

    // Count register: clear wins over increment, increment stops at MAX_VAL
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_r <= {W{1'b0}};
        end else if (clr_i) begin
            count_r <= {W{1'b0}};
        end else if (inc_i && (count_r != MAX_VAL)) begin
            count_r <= count_r + W'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count_o = count_r;

endmodule

// File: rtl/pattern_detector_param.sv
// Moore serial pattern detector: state is the matched-prefix length, next state
// comes from a KMP table built at elaboration; overlap mode is selectable live.
module pattern_detector_param
    import pattern_det_pkg::*;
#(
    parameter int                     PATTERN_LEN = DEFAULT_LEN,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = DEFAULT_PATTERN,
    parameter int                     CNT_W       = 16
)
(
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 valid_i,
    input  logic                                 data_i,
    input  logic                                 overlap_i,
    input  logic                                 clear_i,
    output logic                                 pattern_detected_o,
    output logic [CNT_W-1:0]                     match_count_o,
    output logic [state_width(PATTERN_LEN)-1:0]  prefix_len_o
);

    localparam int                 SW        = state_width(PATTERN_LEN);
    localparam logic [MAX_LEN-1:0] PAT_EXT   = MAX_LEN'(PATTERN);
    localparam logic [TBL_W-1:0]   NEXT_TBL  = build_next_table(PAT_EXT, PATTERN_LEN);
    localparam int                 BORDER    = border_len(PAT_EXT, PATTERN_LEN);
    localparam logic [SW-1:0]      DETECT_K  = SW'(PATTERN_LEN);
    localparam logic [SW-1:0]      BORDER_K  = SW'(BORDER);
    localparam int                 TBL_DEPTH = 2 ** (SW + 1);

    logic [SW-1:0] state_r;
    logic          detected_r;
    logic [SW-1:0] eff_k_s;
    logic [SW-1:0] next_k_s;
    logic          take_s;
    logic          hit_s;
    logic [SW-1:0] next_tbl_s [TBL_DEPTH];

    // Unpack the constant table; unreachable slots are tied off
    for (genvar g = 0; g < TBL_DEPTH; g++) begin : g_tbl
        if (g < 2 * PATTERN_LEN) begin : g_used
            assign next_tbl_s[g] = NEXT_TBL[g * ENTRY_W +: SW];
        end else begin : g_unused
            assign next_tbl_s[g] = {SW{1'b0}};
        end
    end

    // Next-state lookup; the detect state restarts from 0 or from the border
    always_comb begin
        eff_k_s = state_r;
        if (state_r == DETECT_K) begin
            if (overlap_i) begin
                eff_k_s = BORDER_K;
            end else begin
                eff_k_s = {SW{1'b0}};
            end
        end else begin
            eff_k_s = state_r;
        end
        next_k_s = next_tbl_s[{eff_k_s, data_i}];
        take_s   = valid_i & ~clear_i;
        hit_s    = take_s & (next_k_s == DETECT_K);
    end

    // State and registered Moore output; clear beats a same-cycle symbol
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= {SW{1'b0}};
            detected_r <= 1'b0;
        end else if (clear_i) begin
            state_r    <= {SW{1'b0}};
            detected_r <= 1'b0;
        end else if (valid_i) begin
            state_r    <= next_k_s;
            detected_r <= (next_k_s == DETECT_K);
        end else begin
            state_r    <= state_r;
            detected_r <= detected_r;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (hit_s),
        .clr_i   (clear_i),
        .count_o (match_count_o)
    );

    assign pattern_detected_o = detected_r;
    assign prefix_len_o       = state_r;

endmodule

// File: tb/tb_pattern_detector_param.sv
// Directed bench for pattern_detector_param: default pattern, a 2-bit counter
// variant and a 4-symbol all-ones pattern, each with hand-computed expectations.
module tb_pattern_detector_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [2:0] valid_s;
    logic [2:0] data_s;
    logic [2:0] overlap_s;
    logic [2:0] clear_s;

    logic        det_a, det_b, det_c;
    logic [15:0] cnt_a, cnt_c;
    logic [1:0]  cnt_b;
    logic [2:0]  pl_a, pl_b, pl_c;

    int n_tests = 0;
    int n_fail  = 0;

    pattern_detector_param u_dut_a (
        .clk_i (clk), .rst_i (rst), .valid_i (valid_s[0]), .data_i (data_s[0]),
        .overlap_i (overlap_s[0]), .clear_i (clear_s[0]),
        .pattern_detected_o (det_a), .match_count_o (cnt_a), .prefix_len_o (pl_a)
    );

    pattern_detector_param #(.CNT_W (2)) u_dut_b (
        .clk_i (clk), .rst_i (rst), .valid_i (valid_s[1]), .data_i (data_s[1]),
        .overlap_i (overlap_s[1]), .clear_i (clear_s[1]),
        .pattern_detected_o (det_b), .match_count_o (cnt_b), .prefix_len_o (pl_b)
    );

    pattern_detector_param #(.PATTERN_LEN (4), .PATTERN (4'b1111)) u_dut_c (
        .clk_i (clk), .rst_i (rst), .valid_i (valid_s[2]), .data_i (data_s[2]),
        .overlap_i (overlap_s[2]), .clear_i (clear_s[2]),
        .pattern_detected_o (det_c), .match_count_o (cnt_c), .prefix_len_o (pl_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input int u, input logic b);
        data_s[u]  = b;
        valid_s[u] = 1'b1;
        @(posedge clk);
        #1;
        valid_s[u] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr(input int u);
        clear_s[u] = 1'b1;
        @(posedge clk);
        #1;
        clear_s[u] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] stream;
        logic [7:0] exp_nov;
        logic [7:0] exp_ov;
        logic [4:0] pat;
        logic [5:0] exp_c_ov;
        logic [5:0] exp_c_nov;
        int         exp_cnt_b [5];

        stream    = 8'b01101101;
        exp_nov   = 8'b00001000;
        exp_ov    = 8'b00001001;
        pat       = 5'b01101;
        exp_c_ov  = 6'b000111;
        exp_c_nov = 6'b000100;
        exp_cnt_b = '{1, 2, 3, 3, 3};

        rst       = 1'b1;
        valid_s   = 3'b000;
        data_s    = 3'b000;
        overlap_s = 3'b000;
        clear_s   = 3'b000;
        #2;
        check("reset_det", det_a, 1'b0);
        check("reset_cnt", cnt_a, 16'd0);
        check("reset_pl",  pl_a,  3'd0);
        @(negedge clk);
        rst = 1'b0;

        // Non-overlapping: only the first occurrence counts
        overlap_s[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send(0, stream[7 - i]);
            check($sformatf("nov_det%0d", i), det_a, exp_nov[7 - i]);
        end
        check("nov_cnt", cnt_a, 16'd1);
        check("nov_pl",  pl_a,  3'd2);

        clr(0);
        check("clr_cnt", cnt_a, 16'd0);
        check("clr_pl",  pl_a,  3'd0);

        // Overlapping: second detect reuses the "01" border
        overlap_s[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(0, stream[7 - i]);
            check($sformatf("ov_det%0d", i), det_a, exp_ov[7 - i]);
        end
        check("ov_cnt", cnt_a, 16'd2);

        // From detect with overlap: 0 falls back to 1, then 1,1,0 reach prefix 4
        send(0, 1'b0);
        check("fb_pl", pl_a, 3'd1);
        send(0, 1'b1);
        send(0, 1'b1);
        send(0, 1'b0);
        check("pre_rst_pl",  pl_a,  3'd4);
        check("pre_rst_cnt", cnt_a, 16'd2);
        #3;
        rst = 1'b1;
        #1;
        check("arst_pl",  pl_a,  3'd0);
        check("arst_cnt", cnt_a, 16'd0);
        check("arst_det", det_a, 1'b0);
        #1;
        rst = 1'b0;
        send(0, 1'b1);
        check("post_rst_det", det_a, 1'b0);
        check("post_rst_pl",  pl_a,  3'd0);
        check("post_rst_cnt", cnt_a, 16'd0);

        // Idle gaps inside the pattern and a held Moore output afterwards
        overlap_s[0] = 1'b0;
        send(0, 1'b0);
        send(0, 1'b1);
        idle(3);
        check("gap_pl",  pl_a,  3'd2);
        check("gap_det", det_a, 1'b0);
        send(0, 1'b1);
        send(0, 1'b0);
        send(0, 1'b1);
        check("gap_hit_det", det_a, 1'b1);
        check("gap_hit_cnt", cnt_a, 16'd1);
        idle(1);
        check("hold1_det", det_a, 1'b1);
        idle(1);
        check("hold2_det", det_a, 1'b1);
        check("hold2_pl",  pl_a,  3'd5);
        check("hold2_cnt", cnt_a, 16'd1);

        // Saturation of a 2-bit counter
        overlap_s[1] = 1'b1;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 5; i++) begin
                send(1, pat[4 - i]);
            end
            check($sformatf("sat_det%0d", r), det_b, 1'b1);
            check($sformatf("sat_cnt%0d", r), cnt_b, exp_cnt_b[r]);
        end
        clear_s[1] = 1'b1;
        data_s[1]  = 1'b0;
        valid_s[1] = 1'b1;
        @(posedge clk);
        #1;
        clear_s[1] = 1'b0;
        valid_s[1] = 1'b0;
        check("clrv_cnt", cnt_b, 2'd0);
        check("clrv_pl",  pl_b,  3'd0);
        check("clrv_det", det_b, 1'b0);

        // All-ones 4-symbol pattern, overlap on then off
        overlap_s[2] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(2, 1'b1);
            check($sformatf("ones_ov_det%0d", i), det_c, exp_c_ov[5 - i]);
        end
        check("ones_ov_cnt", cnt_c, 16'd3);
        clr(2);
        overlap_s[2] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send(2, 1'b1);
            check($sformatf("ones_nov_det%0d", i), det_c, exp_c_nov[5 - i]);
        end
        check("ones_nov_cnt", cnt_c, 16'd1);
        check("ones_nov_pl",  pl_c,  3'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_detector_param.md
# pattern_detector_param

Parametrised Moore-style serial pattern detector. It tracks a serial bit stream qualified by `valid_i` against a compile-time pattern of arbitrary length. Overlapping versus non-overlapping detection is selected at run time, and the block keeps a saturating match counter. It is the general successor to the fixed five-symbol non-overlapping detector and sits directly on the serial symbol path.

## Interface
- `PATTERN_LEN`, default 5: number of symbols in the pattern; must be ≥ 2.
- `PATTERN`, default 5'b01101: the pattern, MSB first. `PATTERN[PATTERN_LEN-1]` is the first symbol received. The default is B,C,C,B,C with B=0 and C=1.
- `CNT_W`, default 16: width of the match counter.
- `clk_i`  in  1  clock; every register samples on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `valid_i`  in  1  qualifies `data_i`; the block ignores a cycle with `valid_i`=0.
- `data_i`  in  1  serial symbol.
- `overlap_i`  in  1  1 = overlapping detection, 0 = non-overlapping.
- `clear_i`  in  1  synchronous clear of the match state and the counter.
- `pattern_detected_o`  out  1  Moore output; high while the FSM is in the full-match state.
- `match_count_o`  out  CNT_W  number of detections, saturating.
- `prefix_len_o`  out  $clog2(PATTERN_LEN+1)  current matched-prefix length, for debug.

## Operation
- The state is the matched-prefix length `k`, from 0 to `PATTERN_LEN`. `k`=`PATTERN_LEN` is the detect state.
- State transitions are taken only when `valid_i`=1. When `valid_i`=0 the state, the output and the counter all hold.
- The expected symbol at state `k` is `PATTERN[PATTERN_LEN-1-k]`.
- If `k`<`PATTERN_LEN` and `data_i` matches the expected symbol, `k` becomes `k+1`.
- If `k`<`PATTERN_LEN` and `data_i` does not match, `k` becomes the KMP fallback: the longest proper prefix of the pattern that is a suffix of the received symbols, including `data_i`. This can be 0 or nonzero.
- From `k`=`PATTERN_LEN` with `overlap_i`=0: the next symbol is evaluated as if from state 0. This gives the next state 1 or 0.
- From `k`=`PATTERN_LEN` with `overlap_i`=1: the next symbol is evaluated from `F`, the longest proper border of the whole pattern. For the default pattern `F`=2.
- The transition table is computed at elaboration from `PATTERN` by a constant function. No table is computed at run time.
- `pattern_detected_o` = (`k`==`PATTERN_LEN`). Because it is Moore, it stays high until the next valid symbol.
- `match_count_o` increments by 1 on every transition into the detect state. It saturates at 2^CNT_W−1 and does not wrap.
- `clear_i`=1 sets `k` to 0 and the counter to 0, regardless of `valid_i`. `clear_i` takes priority over a same-cycle valid symbol.
- `overlap_i` is sampled only on a valid symbol taken while in the detect state. Changing it at any other time has no effect.

## Timing
- Reset values: `k`=0, `pattern_detected_o`=0, `match_count_o`=0, `prefix_len_o`=0.
- Latency: the valid final pattern symbol is sampled at edge N. `pattern_detected_o` is high from edge N to the next valid edge.
- The counter updates on the same edge as the entry into the detect state.
- When `rst_i` is asserted mid-pattern, all outputs clear immediately without waiting for a clock edge. The partial match is discarded.
- Release of `rst_i` is synchronised externally. The first edge after release may sample a valid symbol.
- Gaps in `valid_i` of any length inside the pattern do not break the match.

## Structure
- The package `pattern_det_pkg` holds:
  - the default pattern constant;
  - the state-width function (`$clog2(PATTERN_LEN+1)`);
  - the constant function that builds the next-state table from `PATTERN` and `PATTERN_LEN`.
- Sub-module `sat_counter` (parameter `W`; ports for increment, clear, and count) implements the saturating match counter.
- The FSM is a single registered state plus combinational next-state logic indexed from the table.

## Test plan
- Default parameters, `overlap_i`=0, stream 0,1,1,0,1,1,0,1 (all valid) → a detect only after the 5th symbol; `match_count_o`=1; final `prefix_len_o`=2.
- The same stream with `overlap_i`=1 → detects after the 5th and 8th symbols; `match_count_o`=2.
- Stream 0,1,1,0 followed by `rst_i` pulsed asynchronously between edges, then 1 → outputs go to 0 immediately; no detect; `match_count_o`=0.
- Valid symbols 0,1 then 3 idle cycles then 1,0,1 → detect after the last symbol; `pattern_detected_o` stays high through 2 further idle cycles.
- `CNT_W`=2, overlap on, pattern repeated 5 times → `match_count_o` reads 1,2,3,3,3; then `clear_i` on the same cycle as a valid symbol → count 0, `prefix_len_o` 0.
- `PATTERN_LEN`=4, `PATTERN`=4'b1111, overlap on, six 1s → detects after the 4th, 5th and 6th symbols; with overlap off, only after the 4th.
